// File: rtl/pattern_ctrl_pkg.sv
// Shared definitions for the pattern apply controller.
//   state_e     : sequencer FSM states
//   MODE_COUNT  : binary up-count pattern source
//   MODE_LFSR   : maximal-length Fibonacci LFSR pattern source
//   lfsr_taps() : feedback tap mask for a given LFSR width (0 = no LFSR available)
package pattern_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_LFSR  = 1'b1;

  // Tap masks for a shift-left Fibonacci LFSR whose feedback bit is the XOR of the
  // masked state bits. Widths without an entry return 0 and the generator falls back
  // to counting; width 1 has no maximal-length LFSR at all.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/pattern_apply_ctrl_pat_gen.sv
// Pattern generator: binary up-counter or maximal-length LFSR.
//   clk, rst_n : clock, asynchronous active-low reset
//   seed_i     : load seed (0 for count, all-ones for LFSR) and latch mode_i
//   adv_i      : step to the next pattern using the latched mode
//   mode_i     : MODE_COUNT / MODE_LFSR, sampled only with seed_i
//   next_o     : value the generator holds after this edge (lets the caller
//                register the new pattern on the same edge it seeds/advances)
module pat_gen
  import pattern_ctrl_pkg::*;
#(
  parameter int PAT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_i,
  input  logic             adv_i,
  input  logic             mode_i,
  output logic [PAT_W-1:0] next_o
);

  localparam logic [PAT_W-1:0] TAPS    = PAT_W'(lfsr_taps(PAT_W));
  localparam bit               LFSR_OK = (TAPS != '0);

  logic             mode_q;
  logic [PAT_W-1:0] value_q;
  logic [PAT_W-1:0] value_d;
  logic [PAT_W-1:0] lfsr_step;

  if (PAT_W > 1) begin : g_shift
    assign lfsr_step = {value_q[PAT_W-2:0], ^(value_q & TAPS)};
  end else begin : g_noshift
    assign lfsr_step = value_q;
  end

  // NOTE: every variable written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (seed_i) begin
      value_d = (mode_i == MODE_LFSR && LFSR_OK) ? '1 : '0;
    end else if (adv_i) begin
      value_d = (mode_q == MODE_LFSR && LFSR_OK) ? lfsr_step : value_q + PAT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_COUNT;
      value_q <= '0;
    end else begin
      if (seed_i) mode_q <= mode_i;
      value_q <= value_d;
    end
  end

  assign next_o = value_d;

endmodule

// File: rtl/pattern_apply_ctrl.sv
// Stimulus sequencer for fault-sim unit benches. For each of num_pat patterns it
// drives pat_out, waits SETTLE cycles, then compares resp_in against exp_in,
// counting mismatches and remembering the first failing index.
//   clk, rst_n  : clock, asynchronous active-low reset (aborts a run, no done)
//   start       : run request, honoured only in IDLE
//   mode        : 0 count / 1 LFSR patterns, latched at start
//   num_pat     : number of patterns, latched at start
//   resp_in     : DUT response, sampled in CAPTURE only
//   exp_in      : golden response, sampled in CAPTURE only
//   pat_out     : stimulus to the DUT, valid from the APPLY cycle on
//   pat_idx     : index of the pattern currently applied
//   busy        : high in APPLY / SETTLE / CAPTURE
//   done        : one-cycle pulse in the DONE state
//   fail_cnt    : saturating mismatch count of the last run
//   first_fail  : index of the first mismatch (meaningful when fail_flag)
//   fail_flag   : at least one mismatch in the last run
module pattern_apply_ctrl
  import pattern_ctrl_pkg::*;
#(
  parameter int PAT_W  = 2,
  parameter int RESP_W = 1,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [CNT_W-1:0]  num_pat,
  input  logic [RESP_W-1:0] resp_in,
  input  logic [RESP_W-1:0] exp_in,
  output logic [PAT_W-1:0]  pat_out,
  output logic [CNT_W-1:0]  pat_idx,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [CNT_W-1:0]  first_fail,
  output logic              fail_flag
);

  localparam int               SC_W        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e            state_q;
  logic [SC_W-1:0]   settle_cnt_q;
  logic [CNT_W-1:0]  num_pat_q;
  logic [PAT_W-1:0]  pat_out_q;
  logic [CNT_W-1:0]  pat_idx_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  fail_cnt_q;
  logic [CNT_W-1:0]  first_fail_q;
  logic              fail_flag_q;

  logic              gen_seed;
  logic              gen_adv;
  logic [PAT_W-1:0]  gen_next;
  logic              last_pat;
  logic              mismatch;

  assign last_pat = (pat_idx_q == num_pat_q - CNT_W'(1));
  assign mismatch = (resp_in != exp_in);
  assign gen_seed = (state_q == ST_IDLE) && start;
  assign gen_adv  = (state_q == ST_CAPTURE) && !last_pat;

  pat_gen #(
    .PAT_W (PAT_W)
  ) u_pat_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .seed_i (gen_seed),
    .adv_i  (gen_adv),
    .mode_i (mode),
    .next_o (gen_next)
  );

  // Outputs are registered alongside the state transition, so each output
  // changes on the same edge that enters the state it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      // NOTE: the latched run length is reset too; it is a plain register, not a
      // memory, and an unreset value would make last_pat X after power-up.
      num_pat_q    <= '0;
      pat_out_q    <= '0;
      pat_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      fail_flag_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            num_pat_q    <= num_pat;
            pat_idx_q    <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            fail_flag_q  <= 1'b0;
            if (num_pat == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_APPLY;
              busy_q    <= 1'b1;
              pat_out_q <= gen_next;
            end
          end
        end

        ST_APPLY: begin
          if (SETTLE == 0) begin
            state_q <= ST_CAPTURE;
          end else begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= SETTLE_LOAD;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt_q == '0) state_q <= ST_CAPTURE;
          else                    settle_cnt_q <= settle_cnt_q - SC_W'(1);
        end

        ST_CAPTURE: begin
          if (mismatch) begin
            if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
            if (!fail_flag_q) begin
              first_fail_q <= pat_idx_q;
              fail_flag_q  <= 1'b1;
            end
          end
          if (last_pat) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= ST_APPLY;
            pat_idx_q <= pat_idx_q + CNT_W'(1);
            pat_out_q <= gen_next;
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pat_out    = pat_out_q;
  assign pat_idx    = pat_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;
  assign fail_flag  = fail_flag_q;

endmodule
